// File: rtl/mnist_pixel_rx.sv
// MNIST pixel receiver: assembles 28x28 pixel streams into a double-buffered frame store
// with random-access readout. Optional partial-frame abort is enabled by defining RX_TIMEOUT_EN.
module mnist_pixel_rx #(
    parameter int DATA_W      = 8,
    parameter int IMG_PIX     = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              in_ready,
    output logic              frame_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              overflow,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIX - 1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;
    logic                in_ready_q, in_ready_d;
    logic                frame_valid_q, frame_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                wr_en_s;
    logic                abort_s;

    logic [DATA_W-1:0]   bank_mem [2][IMG_PIX];

`ifdef RX_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Idle gap counter; the abort fires on the TIMEOUT_CYC-th consecutive empty cycle mid-frame
    always_comb begin
        idle_cnt_d = '0;
        abort_s    = 1'b0;
        if ((state_q != ST_IDLE) && !valid_in) begin
            if (idle_cnt_q == IDLE_LAST) begin
                abort_s = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Write FSM, bank flags and counters
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        wr_en_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    wr_ptr_d = ONE_PTR;
                    if (!full_q[wr_bank_q]) begin
                        wr_en_s = 1'b1;
                        state_d = ST_FILL;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (valid_in) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_q == LAST_PIX) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        frame_count_d     = frame_count_q + 16'd1;
                        wr_ptr_d          = '0;
                        state_d           = ST_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE_PTR;
                    end
                end else if (abort_s) begin
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DROP: begin
                if (valid_in) begin
                    if (wr_ptr_q == LAST_PIX) begin
                        wr_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE_PTR;
                    end
                end else if (abort_s) begin
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                wr_ptr_d = '0;
                state_d  = ST_IDLE;
            end
        endcase

        // A completion only ever sets the write bank, which cannot be the full read bank
        if (frame_done && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Output flags are computed from next state so they can be registered without extra latency
    always_comb begin
        timeout_d     = abort_s;
        in_ready_d    = ((state_d == ST_IDLE) && !full_d[wr_bank_d]) || (state_d == ST_FILL);
        frame_valid_d = full_d[rd_bank_d];
        if (rd_addr <= LAST_PIX) begin
            rd_data_d = bank_mem[rd_bank_q][rd_addr];
        end else begin
            rd_data_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_count_q <= 16'd0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            in_ready_q    <= in_ready_d;
            frame_valid_q <= frame_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Frame store write port; contents need no reset since the full flags gate every use
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            bank_mem[wr_bank_q][wr_ptr_q] <= data_in;
        end
    end

    assign in_ready    = in_ready_q;
    assign frame_valid = frame_valid_q;
    assign rd_data     = rd_data_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mnist_pixel_rx.sv
// Self-checking bench for mnist_pixel_rx: directed scenarios plus random traffic against a
// frame-queue reference model. Define RX_TIMEOUT_EN to also exercise the partial-frame abort.
module tb_mnist_pixel_rx;

    localparam int IMG = 784;
`ifdef RX_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    typedef logic [IMG*8-1:0] frame_t;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        in_ready;
    logic        frame_valid;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic        timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    int to_seen  = 0;
    bit chk_en   = 1'b0;

    // Reference model: queue of complete frames plus progress through the current one
    frame_t      q[$];
    frame_t      cur;
    int          cnt;
    bit          dropping;
    int          idle;
    logic [15:0] m_count;
    bit          m_ovf;
    bit          m_to;
    logic [7:0]  exp_rd;
    bit          rd_known;

    mnist_pixel_rx #(
        .DATA_W(8), .IMG_PIX(IMG), .ADDR_W(10), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .in_ready(in_ready), .frame_valid(frame_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_done(frame_done), .frame_count(frame_count),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cnt      = 0;
            dropping = 1'b0;
            idle     = 0;
            m_count  = 16'd0;
            m_ovf    = 1'b0;
            m_to     = 1'b0;
            exp_rd   = 8'd0;
            rd_known = 1'b1;
        end else begin
            int  pre;
            bit  fin;
            pre  = q.size();
            fin  = 1'b0;
            m_to = 1'b0;
            if (int'(rd_addr) >= IMG) begin
                exp_rd   = 8'd0;
                rd_known = 1'b1;
            end else if (pre > 0) begin
                exp_rd   = q[0][int'(rd_addr)*8 +: 8];
                rd_known = 1'b1;
            end else begin
                rd_known = 1'b0;
            end
            if (valid_in) begin
                idle = 0;
                if (cnt == 0) begin
                    dropping = (pre == 2);
                    if (dropping) m_ovf = 1'b1;
                end
                cur[cnt*8 +: 8] = data_in;
                cnt++;
                if (cnt == IMG) begin
                    cnt = 0;
                    fin = !dropping;
                end
            end else if (cnt > 0) begin
`ifdef RX_TIMEOUT_EN
                idle++;
                if (idle == TO_CYC) begin
                    cnt  = 0;
                    idle = 0;
                    m_to = 1'b1;
                end
`endif
            end
            if (frame_done && pre > 0) void'(q.pop_front());
            if (fin) begin
                q.push_back(cur);
                m_count = m_count + 16'd1;
            end
        end
    end

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        if (timeout_err) to_seen++;
        if (chk_en) begin
            check("in_ready", in_ready, ((cnt == 0 && q.size() < 2) || (cnt > 0 && !dropping)));
            check("frame_valid", frame_valid, (q.size() > 0));
            check("frame_count", frame_count, m_count);
            check("overflow", overflow, m_ovf);
            check("timeout_err", timeout_err, m_to);
            if (rd_known) check("rd_data", rd_data, exp_rd);
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d, input logic dn, input logic [9:0] a);
        valid_in   = v;
        data_in    = d;
        frame_done = dn;
        rd_addr    = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'd0, 1'b0, 10'd0);
        cycle(1'b0, 8'd0, 1'b0, 10'd0);
        rst = 1'b0;
    endtask

    // mode 1 streams (i mod 256); otherwise every pixel is val
    task automatic send_frame(input bit mode, input logic [7:0] val, input bit done_last, input int npix);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] d;
            d = mode ? 8'(i) : val;
            cycle(1'b1, d, done_last && (i == IMG - 1), 10'd300);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = 8'd0; frame_done = 1'b0; rd_addr = 10'd0;
        do_reset();
        chk_en = 1'b1;

        check("reset in_ready", in_ready, 1);
        check("reset frame_valid", frame_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset frame_count", frame_count, 0);
        check("reset overflow", overflow, 0);
        check("reset timeout_err", timeout_err, 0);

        // Ramp frame; last beat makes the frame visible right after it
        send_frame(1'b1, 8'd0, 1'b0, IMG);
        check("s1 frame_valid", frame_valid, 1);
        check("s1 frame_count", frame_count, 1);
        cycle(1'b0, 8'd0, 1'b0, 10'd300);
        check("s1 rd_data@300", rd_data, 8'd44);

        // Three back-to-back frames: third is dropped
        do_reset();
        send_frame(1'b0, 8'h11, 1'b0, IMG);
        send_frame(1'b0, 8'h22, 1'b0, IMG);
        send_frame(1'b0, 8'h33, 1'b0, IMG);
        check("s2 overflow", overflow, 1);
        check("s2 frame_count", frame_count, 2);
        check("s2 in_ready", in_ready, 0);
        cycle(1'b0, 8'd0, 1'b1, 10'd0);
        cycle(1'b0, 8'd0, 1'b0, 10'd0);
        check("s2 rd_data after release", rd_data, 8'h22);

        // Reset in mid-frame discards everything including overflow
        send_frame(1'b0, 8'h5A, 1'b0, 400);
        do_reset();
        send_frame(1'b0, 8'h7F, 1'b0, IMG);
        check("s4 frame_count", frame_count, 1);
        check("s4 overflow", overflow, 0);
        for (int a = 0; a < IMG; a += 97) begin
            cycle(1'b0, 8'd0, 1'b0, 10'(a));
            check("s4 rd_data 7f", rd_data, 8'h7F);
        end
        cycle(1'b0, 8'd0, 1'b0, 10'd783);
        check("s4 rd_data last", rd_data, 8'h7F);
        cycle(1'b0, 8'd0, 1'b0, 10'd800);
        check("s4 rd_data out of range", rd_data, 8'h00);

        // Release coinciding with the last beat of the second frame
        do_reset();
        send_frame(1'b0, 8'h11, 1'b0, IMG);
        send_frame(1'b0, 8'h22, 1'b1, IMG);
        check("s3 frame_valid", frame_valid, 1);
        check("s3 frame_count", frame_count, 2);
        check("s3 in_ready", in_ready, 1);
        cycle(1'b0, 8'd0, 1'b0, 10'd5);
        check("s3 rd_data", rd_data, 8'h22);

        // Release while empty is ignored
        do_reset();
        cycle(1'b0, 8'd0, 1'b1, 10'd0);
        check("s6 frame_valid", frame_valid, 0);
        check("s6 in_ready", in_ready, 1);
        send_frame(1'b0, 8'h3C, 1'b0, IMG);
        cycle(1'b0, 8'd0, 1'b0, 10'd10);
        check("s6 rd_data", rd_data, 8'h3C);

`ifdef RX_TIMEOUT_EN
        do_reset();
        to_seen = 0;
        send_frame(1'b0, 8'h99, 1'b0, 100);
        for (int i = 0; i < TO_CYC; i++) cycle(1'b0, 8'd0, 1'b0, 10'd0);
        send_frame(1'b0, 8'h05, 1'b0, IMG);
        check("s5 timeout pulses", to_seen, 1);
        check("s5 frame_count", frame_count, 1);
        cycle(1'b0, 8'd0, 1'b0, 10'd99);
        check("s5 rd_data@99", rd_data, 8'h05);
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 9000; c++) begin
            logic       v;
            logic       dn;
            logic [9:0] a;
            v  = ($urandom_range(0, 7) != 0);
            dn = ($urandom_range(0, 399) == 0);
            a  = ($urandom_range(0, 9) == 0) ? 10'(784 + $urandom_range(0, 239))
                                             : 10'($urandom_range(0, 783));
            cycle(v, 8'($urandom), dn, a);
            if ($urandom_range(0, 999) == 0) begin
                for (int g = 0; g < 20; g++) cycle(1'b0, 8'd0, 1'b0, 10'($urandom_range(0, 783)));
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
